// File: rtl/input_vc_sa_scheduler_if.sv
// Handshake bundle between the input VC buffers, the output arbiter and the
// per-input-port switch-allocation scheduler. The master modport is the
// scheduler itself. The slave modport is the surrounding router logic.
interface input_vc_sa_scheduler_if #(
   parameter int VC_NUM         = 4,
   parameter int OUT_PORT_NUM   = 5,
   parameter int VC_NUM_IDX_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int OUT_PORT_IDX_W = (OUT_PORT_NUM > 1) ? $clog2(OUT_PORT_NUM) : 1
);
   // head-of-queue status from the input VC buffers
   logic [VC_NUM-1:0]                          vc_head_vld_i;
   logic [VC_NUM-1:0][OUT_PORT_IDX_W-1:0]      vc_head_outport_i;

   // request / grant with the output arbiter
   logic                                       sa_req_vld_o;
   logic [VC_NUM_IDX_W-1:0]                    sa_req_vc_id_o;
   logic [OUT_PORT_IDX_W-1:0]                  sa_req_outport_o;
   logic                                       sa_gnt_i;

   // dequeue controls toward the input VC buffers
   logic                                       inport_read_enable_sa_stage_o;
   logic [VC_NUM_IDX_W-1:0]                    inport_read_vc_id_sa_stage_o;
   logic                                       inport_read_enable_st_stage_o;
   logic [VC_NUM_IDX_W-1:0]                    inport_read_vc_id_st_stage_o;
   logic [OUT_PORT_IDX_W-1:0]                  st_outport_o;

   // credit returns from the downstream routers
   logic [OUT_PORT_NUM-1:0]                    lcrd_v_i;
   logic [OUT_PORT_NUM-1:0][VC_NUM_IDX_W-1:0]  lcrd_id_i;

   modport master (
      input  vc_head_vld_i, vc_head_outport_i, sa_gnt_i, lcrd_v_i, lcrd_id_i,
      output sa_req_vld_o, sa_req_vc_id_o, sa_req_outport_o,
             inport_read_enable_sa_stage_o, inport_read_vc_id_sa_stage_o,
             inport_read_enable_st_stage_o, inport_read_vc_id_st_stage_o,
             st_outport_o
   );

   modport slave (
      output vc_head_vld_i, vc_head_outport_i, sa_gnt_i, lcrd_v_i, lcrd_id_i,
      input  sa_req_vld_o, sa_req_vc_id_o, sa_req_outport_o,
             inport_read_enable_sa_stage_o, inport_read_vc_id_sa_stage_o,
             inport_read_enable_st_stage_o, inport_read_vc_id_st_stage_o,
             st_outport_o
   );
endinterface

// File: rtl/input_vc_sa_scheduler.sv
// First-stage switch allocation for one input port. It picks one eligible VC
// per cycle by round robin, offers it to the output arbiter, and dequeues it
// on grant. It also owns the downstream credit counters per (port, VC). The
// grant is re-timed by one cycle to drive the ST-stage data dequeue and the
// crossbar select.
module input_vc_sa_scheduler #(
   parameter int VC_NUM         = 4,
   parameter int VC_NUM_IDX_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int OUT_PORT_NUM   = 5,
   parameter int OUT_PORT_IDX_W = (OUT_PORT_NUM > 1) ? $clog2(OUT_PORT_NUM) : 1,
   parameter int VC_DEPTH       = 2,
   parameter int CRD_W          = $clog2(VC_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input_vc_sa_scheduler_if.master       bus
);

   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(VC_DEPTH);

   // credit state: one counter per downstream (output port, VC)
   logic [CRD_W-1:0]            crd_reg  [OUT_PORT_NUM][VC_NUM];
   logic [CRD_W-1:0]            crd_next [OUT_PORT_NUM][VC_NUM];
   logic [OUT_PORT_NUM-1:0][VC_NUM-1:0] crd_inc;
   logic [OUT_PORT_NUM-1:0][VC_NUM-1:0] crd_dec;

   // round-robin fairness pointer
   logic [VC_NUM_IDX_W-1:0]     rr_ptr_reg;
   logic [VC_NUM_IDX_W-1:0]     rr_ptr_next;

   // candidate selection
   logic [VC_NUM-1:0]           elig;
   logic                        pick_vld;
   logic [VC_NUM_IDX_W-1:0]     pick_vc;
   logic [OUT_PORT_IDX_W-1:0]   pick_outport;
   logic                        sa_fire;

   // ST-stage pipeline register
   logic                        st_vld_reg;
   logic [VC_NUM_IDX_W-1:0]     st_vc_reg;
   logic [OUT_PORT_IDX_W-1:0]   st_outport_reg;

   // A VC is eligible when its head is valid and the registered credit for
   // its routed (port, VC) is non-zero. A routed port outside the legal range
   // finds no counter, so that VC is never eligible.
   genvar gi, gj;
   generate
      for (gi = 0; gi < VC_NUM; gi++) begin : g_elig
         logic [OUT_PORT_IDX_W-1:0] head_port;
         logic [CRD_W-1:0]          head_crd;

         assign head_port = bus.vc_head_outport_i[gi];

         // look up the credit of this VC on its routed port
         always_comb begin
            head_crd = '0;
            for (int p = 0; p < OUT_PORT_NUM; p++) begin
               if (head_port == OUT_PORT_IDX_W'(p)) begin
                  head_crd = crd_reg[p][gi];
               end
            end
         end

         assign elig[gi] = bus.vc_head_vld_i[gi] && (head_crd != '0);
      end
   endgenerate

   // first eligible VC scanning upward from rr_ptr, wrapping modulo VC_NUM
   always_comb begin
      int                      idx;
      logic [VC_NUM_IDX_W-1:0] idx_vc;
      pick_vld = 1'b0;
      pick_vc  = '0;
      idx      = 0;
      idx_vc   = '0;
      for (int k = 0; k < VC_NUM; k++) begin
         idx    = (int'(rr_ptr_reg) + k) % VC_NUM;
         idx_vc = VC_NUM_IDX_W'(idx);
         if (!pick_vld && elig[idx_vc]) begin
            pick_vld = 1'b1;
            pick_vc  = idx_vc;
         end
      end
   end

   // When nothing is eligible, the id and port outputs read as zero.
   assign pick_outport = pick_vld ? bus.vc_head_outport_i[pick_vc] : '0;
   assign sa_fire      = pick_vld && bus.sa_gnt_i;

   assign bus.sa_req_vld_o                  = pick_vld;
   assign bus.sa_req_vc_id_o                = pick_vc;
   assign bus.sa_req_outport_o              = pick_outport;
   assign bus.inport_read_enable_sa_stage_o = sa_fire;
   assign bus.inport_read_vc_id_sa_stage_o  = pick_vc;
   assign bus.inport_read_enable_st_stage_o = st_vld_reg;
   assign bus.inport_read_vc_id_st_stage_o  = st_vc_reg;
   assign bus.st_outport_o                  = st_outport_reg;

   // With a single VC the pointer never moves.
   generate
      if (VC_NUM == 1) begin : g_rr_const
         assign rr_ptr_next = '0;
      end else begin : g_rr_adv
         // on grant, the pointer moves just past the granted VC
         always_comb begin
            rr_ptr_next = rr_ptr_reg;
            if (sa_fire) begin
               rr_ptr_next = VC_NUM_IDX_W'((int'(pick_vc) + 1) % VC_NUM);
            end
         end
      end
   endgenerate

   // Per-counter increment (credit return) and decrement (granted flit)
   // strobes. Overflow and underflow are protocol errors, so simulation
   // flags them.
   generate
      for (gi = 0; gi < OUT_PORT_NUM; gi++) begin : g_crd_port
         for (gj = 0; gj < VC_NUM; gj++) begin : g_crd_vc
            assign crd_dec[gi][gj] = sa_fire
                                  && (pick_outport == OUT_PORT_IDX_W'(gi))
                                  && (pick_vc == VC_NUM_IDX_W'(gj));
            assign crd_inc[gi][gj] = bus.lcrd_v_i[gi]
                                  && (bus.lcrd_id_i[gi] == VC_NUM_IDX_W'(gj));

            a_crd_overflow: assert property (@(posedge clk) disable iff (!rstn)
               !(crd_inc[gi][gj] && !crd_dec[gi][gj] && (crd_reg[gi][gj] == CRD_FULL)));
            a_crd_underflow: assert property (@(posedge clk) disable iff (!rstn)
               !(crd_dec[gi][gj] && !crd_inc[gi][gj] && (crd_reg[gi][gj] == '0)));
         end
      end
   endgenerate

   // Next credit values. A simultaneous return and grant on one counter
   // cancel. Illegal moves saturate instead of wrapping.
   always_comb begin
      for (int p = 0; p < OUT_PORT_NUM; p++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            crd_next[p][v] = crd_reg[p][v];
            if (crd_inc[p][v] && !crd_dec[p][v] && (crd_reg[p][v] != CRD_FULL)) begin
               crd_next[p][v] = crd_reg[p][v] + CRD_W'(1);
            end else if (crd_dec[p][v] && !crd_inc[p][v] && (crd_reg[p][v] != '0)) begin
               crd_next[p][v] = crd_reg[p][v] - CRD_W'(1);
            end
         end
      end
   end

   // credit counters and round-robin pointer; reset restores full credit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_reg <= '0;
         for (int p = 0; p < OUT_PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               crd_reg[p][v] <= CRD_FULL;
            end
         end
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         for (int p = 0; p < OUT_PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               crd_reg[p][v] <= crd_next[p][v];
            end
         end
      end
   end

   // One-cycle SA-to-ST re-timing of the grant. Id and port are held between
   // grants, and reset drops a pending ST dequeue.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_vld_reg     <= 1'b0;
         st_vc_reg      <= '0;
         st_outport_reg <= '0;
      end else begin
         st_vld_reg <= sa_fire;
         if (sa_fire) begin
            st_vc_reg      <= pick_vc;
            st_outport_reg <= pick_outport;
         end
      end
   end

endmodule

// File: tb/tb_input_vc_sa_scheduler.sv
// Self-checking bench for input_vc_sa_scheduler. It runs a directed vector
// table from reset, then hand-written multi-cycle corner sequences, then
// randomized traffic checked against a credit/round-robin reference model.
module tb_input_vc_sa_scheduler;

   localparam int VC_NUM   = 4;
   localparam int OUT_NUM  = 5;
   localparam int VC_DEPTH = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   input_vc_sa_scheduler_if #(.VC_NUM(VC_NUM), .OUT_PORT_NUM(OUT_NUM)) bus ();

   input_vc_sa_scheduler dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;

   // reference model state
   int m_crd [OUT_NUM][VC_NUM];
   int m_rr;
   bit m_st_vld;
   int m_st_vc;
   int m_st_op;
   bit m_req;
   int m_vc;
   int m_op;

   typedef struct {
      logic [3:0]      vld;
      logic [11:0]     op;
      logic            gnt;
      logic [4:0]      lv;
      logic [9:0]      lid;
      logic            exp_req;
      logic [1:0]      exp_vc;
      logic [2:0]      exp_op;
      logic            exp_st;
      logic [1:0]      exp_st_vc;
      logic [2:0]      exp_st_op;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      for (int p = 0; p < OUT_NUM; p++)
         for (int v = 0; v < VC_NUM; v++)
            m_crd[p][v] = VC_DEPTH;
      m_rr     = 0;
      m_st_vld = 0;
      m_st_vc  = 0;
      m_st_op  = 0;
   endtask

   task automatic drive(input logic [3:0] vld, input logic [11:0] op, input logic gnt,
                        input logic [4:0] lv, input logic [9:0] lid);
      bus.vc_head_vld_i     = vld;
      bus.vc_head_outport_i = op;
      bus.sa_gnt_i          = gnt;
      bus.lcrd_v_i          = lv;
      bus.lcrd_id_i         = lid;
      #1;
   endtask

   // candidate = first VC from rr upward with a valid head and a credit left
   task automatic model_eval();
      m_req = 0;
      m_vc  = 0;
      m_op  = 0;
      for (int k = 0; k < VC_NUM; k++) begin
         int v;
         int p;
         v = (m_rr + k) % VC_NUM;
         p = int'(bus.vc_head_outport_i[v]);
         if (!m_req && bus.vc_head_vld_i[v] && p < OUT_NUM && m_crd[p][v] > 0) begin
            m_req = 1;
            m_vc  = v;
            m_op  = p;
         end
      end
   endtask

   task automatic model_check();
      check("req_vld", int'(bus.sa_req_vld_o), int'(m_req));
      check("req_vc", int'(bus.sa_req_vc_id_o), m_vc);
      check("req_outport", int'(bus.sa_req_outport_o), m_op);
      check("sa_enable", int'(bus.inport_read_enable_sa_stage_o), int'(m_req && bus.sa_gnt_i));
      check("sa_vc", int'(bus.inport_read_vc_id_sa_stage_o), m_vc);
      check("st_enable", int'(bus.inport_read_enable_st_stage_o), int'(m_st_vld));
      if (m_st_vld) begin
         check("st_vc", int'(bus.inport_read_vc_id_st_stage_o), m_st_vc);
         check("st_outport", int'(bus.st_outport_o), m_st_op);
      end
   endtask

   task automatic advance();
      bit fire;
      fire = m_req && bus.sa_gnt_i;
      $display("cyc %0d vld=%b gnt=%0d req=%0d vc=%0d port=%0d st=%0d lcrd=%b",
               cyc, bus.vc_head_vld_i, bus.sa_gnt_i, bus.sa_req_vld_o,
               bus.sa_req_vc_id_o, bus.sa_req_outport_o,
               bus.inport_read_enable_st_stage_o, bus.lcrd_v_i);
      if (fire) begin
         m_crd[m_op][m_vc]--;
         m_rr = (m_vc + 1) % VC_NUM;
      end
      for (int p = 0; p < OUT_NUM; p++)
         if (bus.lcrd_v_i[p]) m_crd[p][int'(bus.lcrd_id_i[p])]++;
      m_st_vld = fire;
      if (fire) begin
         m_st_vc = m_vc;
         m_st_op = m_op;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_cycle(input logic [3:0] vld, input logic [11:0] op, input logic gnt,
                            input logic [4:0] lv, input logic [9:0] lid);
      drive(vld, op, gnt, lv, lid);
      model_eval();
      model_check();
   endtask

   task automatic check_state(input string tag);
      for (int p = 0; p < OUT_NUM; p++)
         for (int v = 0; v < VC_NUM; v++)
            check($sformatf("%s_crd[%0d][%0d]", tag, p, v), int'(dut.crd_reg[p][v]), m_crd[p][v]);
      check($sformatf("%s_rr", tag), int'(dut.rr_ptr_reg), m_rr);
   endtask

   task automatic do_reset();
      drive(4'h0, 12'h0, 1'b0, 5'h0, 10'h0);
      rstn = 1'b0;
      model_reset();
      #1;
      check("rst_st_enable", int'(bus.inport_read_enable_st_stage_o), 0);
      check("rst_st_vc", int'(bus.inport_read_vc_id_st_stage_o), 0);
      check("rst_st_outport", int'(bus.st_outport_o), 0);
      check("rst_req_vld", int'(bus.sa_req_vld_o), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check_state("rst");
   endtask

   initial begin
      // VC0 and VC2 head to port 1 with a grant every cycle. They alternate
      // until both run dry. A credit return is seen only one cycle later.
      tbl[0] = '{4'b0101, 12'h041, 1'b1, 5'b00000, 10'h000, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0};
      tbl[1] = '{4'b0101, 12'h041, 1'b1, 5'b00000, 10'h000, 1'b1, 2'd2, 3'd1, 1'b1, 2'd0, 3'd1};
      tbl[2] = '{4'b0101, 12'h041, 1'b1, 5'b00000, 10'h000, 1'b1, 2'd0, 3'd1, 1'b1, 2'd2, 3'd1};
      tbl[3] = '{4'b0101, 12'h041, 1'b1, 5'b00000, 10'h000, 1'b1, 2'd2, 3'd1, 1'b1, 2'd0, 3'd1};
      tbl[4] = '{4'b0101, 12'h041, 1'b1, 5'b00000, 10'h000, 1'b0, 2'd0, 3'd0, 1'b1, 2'd2, 3'd1};
      tbl[5] = '{4'b0101, 12'h041, 1'b1, 5'b00010, 10'h000, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0};
      tbl[6] = '{4'b0101, 12'h041, 1'b0, 5'b00000, 10'h000, 1'b1, 2'd0, 3'd1, 1'b0, 2'd0, 3'd0};

      bus.vc_head_vld_i     = '0;
      bus.vc_head_outport_i = '0;
      bus.sa_gnt_i          = 1'b0;
      bus.lcrd_v_i          = '0;
      bus.lcrd_id_i         = '0;
      repeat (2) @(posedge clk);
      do_reset();

      // directed table
      for (int i = 0; i < 7; i++) begin
         run_cycle(tbl[i].vld, tbl[i].op, tbl[i].gnt, tbl[i].lv, tbl[i].lid);
         check($sformatf("tbl%0d_req", i), int'(bus.sa_req_vld_o), int'(tbl[i].exp_req));
         check($sformatf("tbl%0d_vc", i), int'(bus.sa_req_vc_id_o), int'(tbl[i].exp_vc));
         check($sformatf("tbl%0d_op", i), int'(bus.sa_req_outport_o), int'(tbl[i].exp_op));
         check($sformatf("tbl%0d_st", i), int'(bus.inport_read_enable_st_stage_o), int'(tbl[i].exp_st));
         if (tbl[i].exp_st) begin
            check($sformatf("tbl%0d_st_vc", i), int'(bus.inport_read_vc_id_st_stage_o), int'(tbl[i].exp_st_vc));
            check($sformatf("tbl%0d_st_op", i), int'(bus.st_outport_o), int'(tbl[i].exp_st_op));
         end
         advance();
      end
      check_state("tbl_end");

      // VC1 to port 3 drains both credits. A return reappears next cycle.
      do_reset();
      run_cycle(4'b0010, 12'h018, 1'b1, 5'h0, 10'h0);
      check("s2_g1_vc", int'(bus.inport_read_vc_id_sa_stage_o), 1);
      advance();
      run_cycle(4'b0010, 12'h018, 1'b1, 5'h0, 10'h0);
      check("s2_g2_en", int'(bus.inport_read_enable_sa_stage_o), 1);
      advance();
      run_cycle(4'b0010, 12'h018, 1'b1, 5'b01000, 10'h040);
      check("s2_empty_req", int'(bus.sa_req_vld_o), 0);
      check("s2_crd31_zero", int'(dut.crd_reg[3][1]), 0);
      advance();
      run_cycle(4'b0010, 12'h018, 1'b0, 5'h0, 10'h0);
      check("s2_return_req", int'(bus.sa_req_vld_o), 1);
      check("s2_return_port", int'(bus.sa_req_outport_o), 3);
      advance();

      // grant and return on crd[2][0] in the same cycle cancel
      do_reset();
      run_cycle(4'b0001, 12'h002, 1'b1, 5'h0, 10'h0);
      advance();
      check("s3_crd20_one", int'(dut.crd_reg[2][0]), 1);
      run_cycle(4'b0001, 12'h002, 1'b1, 5'b00100, 10'h000);
      advance();
      check("s3_crd20_held", int'(dut.crd_reg[2][0]), 1);
      run_cycle(4'b0000, 12'h002, 1'b0, 5'h0, 10'h0);
      advance();

      // all VCs valid, no grant for three cycles: nothing moves
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_cycle(4'b1111, 12'h000, 1'b0, 5'h0, 10'h0);
         check("s4_cand_vc0", int'(bus.sa_req_vc_id_o), 0);
         check("s4_no_sa", int'(bus.inport_read_enable_sa_stage_o), 0);
         check("s4_no_st", int'(bus.inport_read_enable_st_stage_o), 0);
         advance();
      end
      check("s4_rr", int'(dut.rr_ptr_reg), 0);
      for (int v = 0; v < VC_NUM; v++)
         check("s4_crd", int'(dut.crd_reg[0][v]), VC_DEPTH);

      // reset right after a grant kills the pending ST dequeue at once
      do_reset();
      run_cycle(4'b0001, 12'h000, 1'b1, 5'h0, 10'h0);
      advance();
      check("s5_st_before", int'(bus.inport_read_enable_st_stage_o), 1);
      drive(4'h0, 12'h0, 1'b0, 5'h0, 10'h0);
      rstn = 1'b0;
      #1;
      check("s5_st_async_drop", int'(bus.inport_read_enable_st_stage_o), 0);
      check("s5_crd00_full", int'(dut.crd_reg[0][0]), VC_DEPTH);
      check("s5_rr_zero", int'(dut.rr_ptr_reg), 0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check_state("s5_after");

      // returns on ports 0 and 4 in one cycle both apply
      do_reset();
      run_cycle(4'b1010, 12'h800, 1'b1, 5'h0, 10'h0);
      check("s6_g1_vc", int'(bus.sa_req_vc_id_o), 1);
      advance();
      run_cycle(4'b1010, 12'h800, 1'b1, 5'h0, 10'h0);
      check("s6_g2_vc", int'(bus.sa_req_vc_id_o), 3);
      check("s6_g2_op", int'(bus.sa_req_outport_o), 4);
      advance();
      run_cycle(4'b0000, 12'h800, 1'b0, 5'b10001, 10'h301);
      advance();
      check("s6_crd01", int'(dut.crd_reg[0][1]), VC_DEPTH);
      check("s6_crd43", int'(dut.crd_reg[4][3]), VC_DEPTH);

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [3:0]  vld;
         logic [11:0] op;
         logic        gnt;
         logic [4:0]  lv;
         logic [9:0]  lid;
         vld = 4'($urandom_range(0, 15));
         op  = '0;
         for (int v = 0; v < VC_NUM; v++) op[v*3 +: 3] = 3'($urandom_range(0, OUT_NUM - 1));
         gnt = ($urandom_range(0, 9) < 7);
         lv  = '0;
         lid = '0;
         for (int p = 0; p < OUT_NUM; p++) begin
            int id;
            id = int'($urandom_range(0, VC_NUM - 1));
            if ($urandom_range(0, 1) == 1 && m_crd[p][id] < VC_DEPTH) begin
               lv[p]          = 1'b1;
               lid[p*2 +: 2]  = 2'(id);
            end
         end
         run_cycle(vld, op, gnt, lv, lid);
         advance();
         if (i % 50 == 49) check_state("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
